// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 device-side transmitter.
//   ps2_state_e  - serialiser FSM states
//   FRAME_BITS   - start + 8 data + parity + stop
//   SYNC_STAGES  - depth of the line-sense synchroniser
//   INHIBIT_MASK - BIT_HIGH cycles ignored before clk-low means host inhibit
//   ps2_frame()  - builds the frame vector, bit 0 sent first
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, GAP, BIT_HIGH, BIT_LOW, INHIBIT} ps2_state_e;

  localparam int FRAME_BITS   = 11;
  localparam int SYNC_STAGES  = 2;
  localparam int INHIBIT_MASK = 3;

  // {stop, odd parity, data[7:0], start}
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction
endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: synchronous FIFO with occupancy output.
//   clk, rst    - clock, async active-high reset (clears pointers, level, storage)
//   push, wdata - write; caller guarantees not full
//   pop         - drop head; caller guarantees not empty
//   rdata       - current head entry (valid while level != 0)
//   level       - entries held, 0..DEPTH
module ps2_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8   // power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;

  assign rdata = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: PS/2 device-side transmitter. Bytes arrive on a valid/ready
// stream, are buffered, and sent as 11-bit frames on open-drain clk/data lines.
// A host pulling clk low during a BIT_HIGH aborts the frame; the head byte is
// kept and resent from the start bit once the lines have been idle again.
//   clk, rst                   - clock, async active-high reset
//   s_tdata/s_tvalid/s_tready  - input byte stream
//   ps2_clk_in, ps2_data_in    - wired-AND line sense (asynchronous)
//   ps2_clk_oe, ps2_data_oe    - 1 = pull line low
//   busy                       - frame in progress or bytes queued
//   fifo_level                 - bytes held, including the one in flight
//   frame_abort                - one-cycle pulse on host inhibit
// Optional: define PS2_TX_RESEND_EN to add resend_req, which re-queues the last
// completed byte ahead of the FIFO head (host 0xFE "Resend").
module ps2_device_tx import ps2_pkg::*; #(
  parameter int CLK_DIV    = 4000,  // clocks per half bit, >= 4
  parameter int FIFO_DEPTH = 8,     // power of two, >= 2
  parameter int IDLE_GAP   = 5000   // clocks of idle lines before a frame
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic                          ps2_clk_in,
  input  logic                          ps2_data_in,
`ifdef PS2_TX_RESEND_EN
  input  logic                          resend_req,
`endif
  output logic                          ps2_clk_oe,
  output logic                          ps2_data_oe,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_abort
);
  localparam int LW      = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_MAX = (IDLE_GAP > CLK_DIV) ? IDLE_GAP : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] GAP_END  = CW'(IDLE_GAP);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] MASK_CNT = CW'(INHIBIT_MASK);
  localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);

  ps2_state_e             state;
  logic [CW-1:0]          cnt;
  logic [3:0]             idx;
  logic [7:0]             tx_byte;
  logic [FRAME_BITS-1:0]  frame;
  logic [7:0]             fifo_head;
  logic                   push, pop, frame_done;
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   sclk, sdat;

  // Line sense synchroniser; every decision below uses the synced copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '0;
      dat_sync <= '0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data_in};
    end
  end
  assign sclk = clk_sync[SYNC_STAGES-1];
  assign sdat = dat_sync[SYNC_STAGES-1];

  assign frame      = ps2_frame(tx_byte);
  assign s_tready   = (fifo_level < DEPTH_L);
  assign push       = s_tvalid && s_tready;
  assign busy       = (state != IDLE) || (fifo_level != '0);
  // Stop bit has been clocked: the byte counts as delivered.
  assign frame_done = (state == BIT_LOW) && (cnt == HALF_END) && (idx == LAST_BIT);

`ifdef PS2_TX_RESEND_EN
  logic [7:0] last_byte;
  logic       last_valid, resend_pend, from_resend;
  // A resent byte never came from the FIFO, so it must not pop it.
  assign pop = frame_done && !from_resend;
`else
  assign pop = frame_done;
`endif

  ps2_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (s_tdata),
    .pop   (pop),
    .rdata (fifo_head),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      tx_byte     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      frame_abort <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      last_byte   <= '0;
      last_valid  <= 1'b0;
      resend_pend <= 1'b0;
      from_resend <= 1'b0;
`endif
    end else begin
      frame_abort <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      if (resend_req && last_valid) resend_pend <= 1'b1;
      if (frame_done) begin
        last_byte   <= tx_byte;
        last_valid  <= 1'b1;
        from_resend <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
`ifdef PS2_TX_RESEND_EN
          if (resend_pend) begin
            tx_byte     <= last_byte;
            from_resend <= 1'b1;
            resend_pend <= 1'b0;
            state       <= GAP;
          end else
`endif
          if (fifo_level != '0) begin
            tx_byte <= fifo_head;
            state   <= GAP;
          end
        end
        // Any low line (inhibit or request-to-send) restarts the idle count.
        GAP: begin
          if (!sclk || !sdat) cnt <= '0;
          else if (cnt == GAP_END) begin
            cnt         <= '0;
            idx         <= '0;
            ps2_data_oe <= ~frame[0];
            state       <= BIT_HIGH;
          end else cnt <= cnt + 1'b1;
        end
        // The first cycles see our own clk-low still in the synchroniser.
        BIT_HIGH: begin
          if (cnt >= MASK_CNT && !sclk) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            frame_abort <= 1'b1;
            cnt         <= '0;
            state       <= INHIBIT;
          end else if (cnt == HALF_END) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= BIT_LOW;
          end else cnt <= cnt + 1'b1;
        end
        BIT_LOW: begin
          if (cnt == HALF_END) begin
            cnt        <= '0;
            ps2_clk_oe <= 1'b0;
            if (idx == LAST_BIT) begin
              ps2_data_oe <= 1'b0;
              state       <= IDLE;
            end else begin
              idx         <= idx + 1'b1;
              ps2_data_oe <= ~frame[idx + 1'b1];
              state       <= BIT_HIGH;
            end
          end else cnt <= cnt + 1'b1;
        end
        INHIBIT: begin
          cnt   <= '0;
          state <= GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_device_tx.sv
module tb_ps2_device_tx;
  localparam int CLK_DIV = 4, FIFO_DEPTH = 4, IDLE_GAP = 8;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0, s_tready;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       busy, frame_abort;
  logic [2:0] fifo_level;
  logic       host_clk_low = 1'b0, host_data_low = 1'b0;
`ifdef PS2_TX_RESEND_EN
  logic       resend_req = 1'b0;
`endif

  // Open-drain wired-AND of device and host pull-downs.
  assign ps2_clk_in  = ~(ps2_clk_oe  | host_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | host_data_low);

  ps2_device_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .IDLE_GAP(IDLE_GAP)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
`ifdef PS2_TX_RESEND_EN
    .resend_req(resend_req),
`endif
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .fifo_level(fifo_level), .frame_abort(frame_abort));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int lim);
    tests++;
    if (act < lim) begin
      fails++;
      $display("FAIL %s: got %0d expected >= %0d", name, act, lim);
    end
  endtask

  // Reference: frame as a host sees it, bit 0 first.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  // Host-side receiver: samples data when the device pulls clk low.
  logic [10:0] rxq[$];
  logic [10:0] sh = '0;
  int nb = 0, run = 0, pulses = 0, aborts = 0, cyc = 0, last_end = -1;
  logic prev_oe = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      nb = 0; run = 0; prev_oe = 1'b0; last_end = -1;
    end else begin
      if (frame_abort) begin aborts++; nb = 0; end
      if (ps2_clk_oe) begin
        if (!prev_oe) begin
          if (nb == 0 && last_end >= 0) check_ge("frame_gap", cyc - last_end, IDLE_GAP);
          if (nb < 11) sh[nb] = ps2_data_in;
          nb++; pulses++;
        end
        run++;
      end else if (prev_oe) begin
        check("clk_low_width", run, CLK_DIV);
        run = 0;
        if (nb == 11) begin rxq.push_back(sh); nb = 0; last_end = cyc; end
      end
      prev_oe = ps2_clk_oe;
    end
  end

  task automatic push(input logic [7:0] b);
    int g = 0;
    s_tdata = b; s_tvalid = 1'b1;
    while (!s_tready && g < 3000) begin @(negedge clk); g++; end
    if (g >= 3000) begin tests++; fails++; $display("FAIL push_timeout: byte %0h not accepted", b); end
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int g = 0;
    while (rxq.size() < n && g < 5000) begin @(negedge clk); g++; end
    check("rx_count", rxq.size(), n);
  endtask

  typedef struct { logic [7:0] data; logic par; } vec_t;
  vec_t tbl [6];
  logic [7:0] five [5];
  logic [7:0] expq[$];
  logic [10:0] f;
  int lat, p0, a0, i, g;

  initial begin
    tbl[0] = '{8'hFF, 1'b1}; tbl[1] = '{8'hA5, 1'b1}; tbl[2] = '{8'h07, 1'b0};
    tbl[3] = '{8'h00, 1'b1}; tbl[4] = '{8'h80, 1'b0}; tbl[5] = '{8'hC3, 1'b1};
    five = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (3) @(negedge clk);
    check("rst_tready", s_tready, 1);  check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0); check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0); check("rst_abort", frame_abort, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single 0xFF: latency, frame content, pulse count, drain.
    p0 = pulses;
    s_tdata = 8'hFF; s_tvalid = 1'b1;
    @(negedge clk); s_tvalid = 1'b0;
    check("t1_level_after_push", fifo_level, 1);
    check("t1_busy_after_push", busy, 1);
    lat = 0;
    while (!ps2_clk_oe && lat < 200) begin @(negedge clk); lat++; end
    check("t1_first_fall_latency", lat, IDLE_GAP + CLK_DIV + 2);
    wait_rx(1);
    f = rxq.pop_front();
    check("t1_frame", f, 11'h7FE);
    check("t1_pulses", pulses - p0, 11);
    check("t1_level_end", fifo_level, 0);
    check("t1_busy_end", busy, 0);

    // Table: back-to-back bytes with hand-computed parity.
    for (int k = 0; k < 6; k++) push(tbl[k].data);
    wait_rx(6);
    for (int k = 0; k < 6; k++) begin
      f = rxq.pop_front();
      check($sformatf("tbl_frame_%0d", k), f, {1'b1, tbl[k].par, tbl[k].data, 1'b0});
    end
    g = 0;
    while (busy && g < 500) begin @(negedge clk); g++; end

    // Five bytes with valid held: backpressure after four.
    p0 = pulses; i = 0; g = 0;
    s_tdata = five[0]; s_tvalid = 1'b1;
    while (i < 5 && g < 3000) begin
      if (s_tready) begin
        if (i == 4) begin
          check("t3_rise_on_completion", pulses - p0, 11);
          check("t3_level_at_rise", fifo_level, 3);
        end
        @(negedge clk); i++;
        if (i < 5) s_tdata = five[i];
        if (i == 4) check("t3_tready_full", s_tready, 0);
      end else begin
        @(negedge clk); g++;
      end
    end
    s_tvalid = 1'b0;
    check("t3_accepted", i, 5);
    wait_rx(5);
    for (int k = 0; k < 5; k++) begin
      f = rxq.pop_front();
      check($sformatf("t3_order_%0d", k), f, exp_frame(five[k]));
    end

    // Host inhibit during bit 5 high phase.
    a0 = aborts;
    push(8'hC3);
    g = 0;
    while (!(nb == 5 && !ps2_clk_oe) && g < 500) begin @(negedge clk); g++; end
    host_clk_low = 1'b1;
    g = 0;
    while (!frame_abort && g < 50) begin @(negedge clk); g++; end
    check("t4_abort_seen", frame_abort, 1);
    check("t4_clk_released", ps2_clk_oe, 0);
    check("t4_data_released", ps2_data_oe, 0);
    check("t4_level_kept", fifo_level, 1);
    @(negedge clk);
    check("t4_abort_one_cycle", frame_abort, 0);
    repeat (15) @(negedge clk);
    check("t4_no_pulse_inhibited", ps2_clk_oe, 0);
    host_clk_low = 1'b0;
    wait_rx(1);
    f = rxq.pop_front();
    check("t4_resent_frame", f, exp_frame(8'hC3));
    check("t4_abort_count", aborts - a0, 1);

    // Reset mid-frame during bit 3.
    push(8'h5A); push(8'h3C);
    g = 0;
    while (!(nb == 4 && ps2_clk_oe) && g < 500) begin @(negedge clk); g++; end
    #2 rst = 1'b1;
    #1;
    check("t5_clk_oe", ps2_clk_oe, 0); check("t5_data_oe", ps2_data_oe, 0);
    check("t5_level", fifo_level, 0);  check("t5_tready", s_tready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    repeat (200) @(negedge clk);
    check("t5_no_pulses", pulses - p0, 0);
    check("t5_rx_empty", rxq.size(), 0);
    check("t5_busy", busy, 0);

    // Host holds data low (request-to-send) with a byte queued.
    host_data_low = 1'b1;
    p0 = pulses;
    push(8'h3C);
    repeat (60) @(negedge clk);
    check("t6_held_pulses", pulses - p0, 0);
    check("t6_held_data_oe", ps2_data_oe, 0);
    check("t6_held_busy", busy, 1);
    host_data_low = 1'b0;
    lat = 0;
    while (!ps2_data_oe && lat < 200) begin @(negedge clk); lat++; end
    // One edge samples the release, then IDLE_GAP+2 to the start bit.
    check("t6_start_latency", lat, 1 + IDLE_GAP + 2);
    wait_rx(1);
    f = rxq.pop_front();
    check("t6_frame", f, exp_frame(8'h3C));

    // Randomised bytes and gaps against the reference frame model.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      b = 8'($urandom);
      expq.push_back(b);
      push(b);
      repeat ($urandom_range(0, 120)) @(negedge clk);
    end
    g = 0;
    while ((busy || rxq.size() < 24) && g < 10000) begin @(negedge clk); g++; end
    check("rnd_count", rxq.size(), 24);
    while (rxq.size() > 0 && expq.size() > 0) begin
      f = rxq.pop_front();
      check("rnd_frame", f, exp_frame(expq.pop_front()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
